// File: rtl/wbi_pkg.sv
// Shared definitions for the Wishbone-to-command master node.
//   - wbi_state_e : node FSM states
//   - TID_W       : width of the transaction ID carried on commands and responses
package wbi_pkg;

   localparam int unsigned TID_W = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_WAIT  = 2'd2
   } wbi_state_e;

endpackage

// File: rtl/wbi_cmd_slot.sv
// One-entry valid/ready holding register for outgoing commands.
//
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : write data_i into the slot (honoured only while ready_o)
//   data_i       : command word to store
//   ready_o      : slot can take a word this cycle (empty, or emptying now)
//   valid_o      : slot holds a command
//   data_o       : stored command word
//   accept_i     : downstream takes the stored command this cycle
module wbi_cmd_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic         ready_o,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   input  logic         accept_i
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Pass-through readiness lets a new word land in the same cycle the old one leaves.
   assign ready_o = !valid_q || accept_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i && ready_o) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (accept_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/wbi_master_node.sv
// Wishbone master-side node: turns Wishbone burst requests into single-beat
// commands (one per write beat, one per read burst) and returns read responses.
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   wbm_cyc_i/stb_i/we_i  : Wishbone request qualifiers
//   wbm_adr_i/dat_i/sel_i : request address, write data, byte enables
//   wbm_bl_i              : burst length (0 treated as 1)
//   wbm_bry_i             : write beat available / read data accepted
//   wbm_dat_o             : read data
//   wbm_ack_o/lack_o/err_o: beat ack, last-beat ack, error
//   cmd_*                 : registered command channel (cmd_tid_o fixed to MID)
//   res_*                 : read response channel
module wbi_master_node
   import wbi_pkg::*;
#(
   parameter int unsigned       AW  = 32,
   parameter int unsigned       DW  = 32,
   parameter int unsigned       BW  = 4,
   parameter int unsigned       BL  = 10,
   parameter logic [TID_W-1:0]  MID = 4'h0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wbm_cyc_i,
   input  logic             wbm_stb_i,
   input  logic             wbm_we_i,
   input  logic [AW-1:0]    wbm_adr_i,
   input  logic [DW-1:0]    wbm_dat_i,
   input  logic [BW-1:0]    wbm_sel_i,
   input  logic [BL-1:0]    wbm_bl_i,
   input  logic             wbm_bry_i,
   output logic [DW-1:0]    wbm_dat_o,
   output logic             wbm_ack_o,
   output logic             wbm_lack_o,
   output logic             wbm_err_o,
   output logic             cmd_val_o,
   input  logic             cmd_wrdy_i,
   output logic [AW-1:0]    cmd_adr_o,
   output logic             cmd_we_o,
   output logic [DW-1:0]    cmd_dat_o,
   output logic [BW-1:0]    cmd_sel_o,
   output logic [BL-1:0]    cmd_bl_o,
   output logic [TID_W-1:0] cmd_tid_o,
   input  logic             res_rval_i,
   output logic             res_rrdy_o,
   input  logic [DW-1:0]    res_dat_i,
   input  logic             res_lack_i,
   input  logic             res_err_i,
   input  logic [TID_W-1:0] res_tid_i
);

   // Command word layout: {adr, we, dat, sel, bl}
   localparam int unsigned CW = AW + 1 + DW + BW + BL;
   localparam logic [BL-1:0] BL_ONE = {{(BL-1){1'b0}}, 1'b1};

   wbi_state_e    state_q, state_d;
   logic [BL-1:0] cnt_q, cnt_d;      // write beats already captured in this burst
   logic [BL-1:0] blen_q, blen_d;    // effective burst length latched at beat 1
   logic          drain_q, drain_d;  // read abandoned by master: swallow responses
   logic [BL-1:0] eff_bl;
   logic [BL-1:0] beat_num;
   logic          cap_ok;
   logic          load;
   logic [CW-1:0] load_data;
   logic [CW-1:0] slot_data;

   assign eff_bl   = (wbm_bl_i == '0) ? BL_ONE : wbm_bl_i;
   assign beat_num = cnt_q + BL_ONE;

   wbi_cmd_slot #(
      .W (CW)
   ) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (load),
      .data_i   (load_data),
      .ready_o  (cap_ok),
      .valid_o  (cmd_val_o),
      .data_o   (slot_data),
      .accept_i (cmd_wrdy_i)
   );

   assign {cmd_adr_o, cmd_we_o, cmd_dat_o, cmd_sel_o, cmd_bl_o} = slot_data;
   assign cmd_tid_o = MID;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         blen_q  <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blen_q  <= blen_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      blen_d     = blen_q;
      drain_d    = drain_q;
      load       = 1'b0;
      load_data  = '0;
      wbm_ack_o  = 1'b0;
      wbm_lack_o = 1'b0;
      wbm_err_o  = 1'b0;
      wbm_dat_o  = '0;
      res_rrdy_o = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            drain_d = 1'b0;
            if (wbm_cyc_i && wbm_stb_i && cap_ok) begin
               if (wbm_we_i) begin
                  if (wbm_bry_i) begin
                     load      = 1'b1;
                     load_data = {wbm_adr_i, 1'b1, wbm_dat_i, wbm_sel_i, eff_bl};
                     wbm_ack_o = 1'b1;
                     if (eff_bl == BL_ONE) begin
                        wbm_lack_o = 1'b1;
                     end else begin
                        state_d = WR_BURST;
                        cnt_d   = BL_ONE;
                        blen_d  = eff_bl;
                     end
                  end
               end else begin
                  // One command covers the whole read burst; data field unused.
                  load      = 1'b1;
                  load_data = {wbm_adr_i, 1'b0, {DW{1'b0}}, wbm_sel_i, eff_bl};
                  state_d   = RD_WAIT;
               end
            end
         end

         WR_BURST: begin
            if (!wbm_cyc_i) begin
               // Abandoned burst; any captured beat stays in the slot until taken.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (wbm_stb_i && wbm_bry_i && cap_ok) begin
               load      = 1'b1;
               load_data = {wbm_adr_i, 1'b1, wbm_dat_i, wbm_sel_i, blen_q};
               wbm_ack_o = 1'b1;
               cnt_d     = beat_num;
               if (beat_num == blen_q) begin
                  wbm_lack_o = 1'b1;
                  state_d    = IDLE;
                  cnt_d      = '0;
               end
            end
         end

         RD_WAIT: begin
            wbm_dat_o = res_dat_i;
            if (drain_q || !wbm_cyc_i) begin
               // Once the master walks away, keep consuming until the last beat.
               res_rrdy_o = 1'b1;
               drain_d    = 1'b1;
            end else begin
               res_rrdy_o = wbm_bry_i;
               wbm_ack_o  = res_rval_i && wbm_bry_i;
               wbm_lack_o = wbm_ack_o && res_lack_i;
               wbm_err_o  = wbm_ack_o && (res_err_i || (res_tid_i != MID));
            end
            if (res_rval_i && res_rrdy_o && res_lack_i) begin
               state_d = IDLE;
               drain_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // The IDLE write ack is combinational from inputs, so mask it during reset.
      if (rst_i) begin
         load       = 1'b0;
         wbm_ack_o  = 1'b0;
         wbm_lack_o = 1'b0;
         wbm_err_o  = 1'b0;
         wbm_dat_o  = '0;
         res_rrdy_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_wbi_master_node.sv
module tb_wbi_master_node;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned BW  = 4;
   localparam int unsigned BL  = 10;
   localparam logic [3:0]  MID = 4'h0;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_bry_i;
   logic [AW-1:0] wbm_adr_i;
   logic [DW-1:0] wbm_dat_i;
   logic [BW-1:0] wbm_sel_i;
   logic [BL-1:0] wbm_bl_i;
   logic [DW-1:0] wbm_dat_o;
   logic          wbm_ack_o, wbm_lack_o, wbm_err_o;
   logic          cmd_val_o, cmd_wrdy_i;
   logic [AW-1:0] cmd_adr_o;
   logic          cmd_we_o;
   logic [DW-1:0] cmd_dat_o;
   logic [BW-1:0] cmd_sel_o;
   logic [BL-1:0] cmd_bl_o;
   logic [3:0]    cmd_tid_o;
   logic          res_rval_i, res_rrdy_o;
   logic [DW-1:0] res_dat_i;
   logic          res_lack_i, res_err_i;
   logic [3:0]    res_tid_i;

   always #5 clk_i = ~clk_i;

   wbi_master_node #(
      .AW  (AW),
      .DW  (DW),
      .BW  (BW),
      .BL  (BL),
      .MID (MID)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wbm_cyc_i  (wbm_cyc_i),
      .wbm_stb_i  (wbm_stb_i),
      .wbm_we_i   (wbm_we_i),
      .wbm_adr_i  (wbm_adr_i),
      .wbm_dat_i  (wbm_dat_i),
      .wbm_sel_i  (wbm_sel_i),
      .wbm_bl_i   (wbm_bl_i),
      .wbm_bry_i  (wbm_bry_i),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_ack_o  (wbm_ack_o),
      .wbm_lack_o (wbm_lack_o),
      .wbm_err_o  (wbm_err_o),
      .cmd_val_o  (cmd_val_o),
      .cmd_wrdy_i (cmd_wrdy_i),
      .cmd_adr_o  (cmd_adr_o),
      .cmd_we_o   (cmd_we_o),
      .cmd_dat_o  (cmd_dat_o),
      .cmd_sel_o  (cmd_sel_o),
      .cmd_bl_o   (cmd_bl_o),
      .cmd_tid_o  (cmd_tid_o),
      .res_rval_i (res_rval_i),
      .res_rrdy_o (res_rrdy_o),
      .res_dat_i  (res_dat_i),
      .res_lack_i (res_lack_i),
      .res_err_i  (res_err_i),
      .res_tid_i  (res_tid_i)
   );

   typedef struct packed {
      logic [AW-1:0] adr;
      logic          we;
      logic [DW-1:0] dat;
      logic [BW-1:0] sel;
      logic [BL-1:0] bl;
      logic [3:0]    tid;
   } cmd_t;

   int   total = 0;
   int   bad   = 0;
   cmd_t exp_q[$];
   cmd_t got_q[$];
   bit   occ = 1'b0;  // reference: a command is waiting for acceptance

   logic          s_ack, s_lack, s_err, s_rrdy, s_cval;
   logic [DW-1:0] s_dat;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven 1 time unit after posedge; outputs sampled at negedge.
   task automatic cycle();
      @(negedge clk_i);
      s_ack  = wbm_ack_o;
      s_lack = wbm_lack_o;
      s_err  = wbm_err_o;
      s_rrdy = res_rrdy_o;
      s_cval = cmd_val_o;
      s_dat  = wbm_dat_o;
      if (cmd_val_o && cmd_wrdy_i)
         got_q.push_back('{cmd_adr_o, cmd_we_o, cmd_dat_o, cmd_sel_o, cmd_bl_o, cmd_tid_o});
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      wbm_cyc_i  = 1'b0;
      wbm_stb_i  = 1'b0;
      wbm_we_i   = 1'b0;
      wbm_bry_i  = 1'b0;
      wbm_adr_i  = '0;
      wbm_dat_i  = '0;
      wbm_sel_i  = '0;
      wbm_bl_i   = '0;
      res_rval_i = 1'b0;
      res_dat_i  = '0;
      res_lack_i = 1'b0;
      res_err_i  = 1'b0;
      res_tid_i  = MID;
   endtask

   // Let any pending command drain, then compare issued commands with expectations.
   task automatic finish_cmds(input string tag);
      wbm_cyc_i  = 1'b0;
      wbm_stb_i  = 1'b0;
      cmd_wrdy_i = 1'b1;
      cycle();
      chk({tag, "_flush_cval"}, 128'(s_cval), 128'(occ));
      chk({tag, "_flush_ack"}, 128'(s_ack), 128'(0));
      occ = 1'b0;
      chk({tag, "_ncmd"}, 128'(got_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({tag, "_cmd"}, 128'(got_q[i]), 128'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic wr_burst(input logic [BL-1:0] blf, input logic [AW-1:0] base,
                           input logic [DW-1:0] d0, input bit directed, input int rdy_pct,
                           input bit stall2, input int abort_at);
      int   n, beat, guard, stall, acks;
      logic exp_ack;
      cmd_t c;
      n     = (blf == '0) ? 1 : int'(blf);
      beat  = 0;
      guard = 0;
      stall = 0;
      acks  = 0;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      wbm_we_i  = 1'b1;
      wbm_bl_i  = blf;
      wbm_adr_i = base;
      wbm_dat_i = d0;
      wbm_sel_i = BW'($urandom);
      while (beat < n && beat != abort_at && guard < 300) begin
         guard++;
         wbm_bry_i = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (stall > 0) begin
            cmd_wrdy_i = 1'b0;
            stall--;
         end else begin
            cmd_wrdy_i = directed ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
         end
         exp_ack = wbm_bry_i && (!occ || cmd_wrdy_i);
         c = '{wbm_adr_i, 1'b1, wbm_dat_i, wbm_sel_i, BL'(n), MID};
         cycle();
         chk("wr_ack", 128'(s_ack), 128'(exp_ack));
         chk("wr_lack", 128'(s_lack), 128'(exp_ack && (beat == n - 1)));
         chk("wr_cval", 128'(s_cval), 128'(occ));
         if (s_ack) acks++;
         occ = exp_ack || (occ && !cmd_wrdy_i);
         if (exp_ack) begin
            exp_q.push_back(c);
            beat++;
            wbm_adr_i = wbm_adr_i + AW'(4);
            wbm_dat_i = $urandom;
            wbm_sel_i = BW'($urandom);
            if (stall2 && beat == 2) stall = 3;
         end
      end
      chk("wr_beats", 128'(acks), 128'((abort_at >= 0) ? abort_at : n));
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      wbm_bry_i = 1'b0;
      if (abort_at >= 0) begin
         cmd_wrdy_i = 1'b0;
         cycle();
         chk("abort_ack", 128'(s_ack), 128'(0));
         chk("abort_cval", 128'(s_cval), 128'(occ));
      end
   endtask

   // mode 0: bry toggles 1/0, response always valid, data = beat index.
   // mode 1: random bry/valid/data/err.
   task automatic rd_burst(input logic [BL-1:0] blf, input int mode, input int tid_bad,
                           input int drop_after, input int hold);
      int            n, k, guard, dut_acks, tog;
      bit            dropped, exp_cap;
      logic          exp_rrdy, exp_ack, er;
      logic [DW-1:0] d;
      n        = (blf == '0) ? 1 : int'(blf);
      k        = 0;
      guard    = 0;
      dut_acks = 0;
      tog      = 0;
      dropped  = 1'b0;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      wbm_we_i  = 1'b0;
      wbm_bry_i = 1'($urandom);
      wbm_bl_i  = blf;
      wbm_adr_i = $urandom;
      wbm_dat_i = $urandom;
      wbm_sel_i = BW'($urandom);
      do begin
         guard++;
         cmd_wrdy_i = (hold > 0) ? 1'b0 : 1'b1;
         exp_cap = !occ || cmd_wrdy_i;
         cycle();
         chk("rd_cap_ack", 128'(s_ack), 128'(0));
         chk("rd_cap_rrdy", 128'(s_rrdy), 128'(0));
         chk("rd_cap_cval", 128'(s_cval), 128'(occ));
         occ = exp_cap || (occ && !cmd_wrdy_i);
         if (exp_cap)
            exp_q.push_back('{wbm_adr_i, 1'b0, {DW{1'b0}}, wbm_sel_i, BL'(n), MID});
         hold--;
      end while (!exp_cap && guard < 50);
      wbm_stb_i  = 1'b0;
      cmd_wrdy_i = 1'b1;
      guard      = 0;
      while (k < n && guard < 400) begin
         guard++;
         if (mode == 0) begin
            wbm_bry_i  = (tog % 2 == 0);
            tog++;
            res_rval_i = 1'b1;
            d          = DW'(k);
            er         = 1'b0;
         end else begin
            wbm_bry_i  = 1'($urandom_range(0, 1));
            res_rval_i = ($urandom_range(0, 2) != 0);
            d          = $urandom;
            er         = ($urandom_range(0, 7) == 0);
         end
         res_dat_i  = d;
         res_err_i  = er;
         res_lack_i = (k == n - 1);
         res_tid_i  = (k == tid_bad) ? MID + 4'd1 : MID;
         wbm_cyc_i  = !dropped;
         exp_rrdy   = dropped ? 1'b1 : wbm_bry_i;
         exp_ack    = !dropped && res_rval_i && wbm_bry_i;
         cycle();
         chk("rd_rrdy", 128'(s_rrdy), 128'(exp_rrdy));
         chk("rd_ack", 128'(s_ack), 128'(exp_ack));
         chk("rd_lack", 128'(s_lack), 128'(exp_ack && (k == n - 1)));
         chk("rd_err", 128'(s_err), 128'(exp_ack && (er || (k == tid_bad))));
         chk("rd_cval", 128'(s_cval), 128'(occ));
         if (exp_ack) chk("rd_dat", 128'(s_dat), 128'(d));
         occ = 1'b0;
         if (s_ack) dut_acks++;
         if (res_rval_i && exp_rrdy) k++;
         if (drop_after > 0 && dut_acks == drop_after) dropped = 1'b1;
      end
      chk("rd_beats", 128'(k), 128'(n));
      chk("rd_acks", 128'(dut_acks), 128'((drop_after > 0) ? drop_after : n));
      // Back in IDLE: a stray response must not be taken.
      idle_inputs();
      res_rval_i = 1'b1;
      cycle();
      chk("rd_idle_rrdy", 128'(s_rrdy), 128'(0));
      chk("rd_idle_ack", 128'(s_ack), 128'(0));
      res_rval_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      cmd_wrdy_i = 1'b0;
      rst_i      = 1'b1;
      // Hostile inputs during reset must not leak through.
      wbm_cyc_i  = 1'b1;
      wbm_stb_i  = 1'b1;
      wbm_we_i   = 1'b1;
      wbm_bry_i  = 1'b1;
      wbm_bl_i   = BL'(1);
      res_rval_i = 1'b1;
      res_dat_i  = 32'hDEAD_BEEF;
      #2;
      chk("rst_ack", 128'(wbm_ack_o), 128'(0));
      chk("rst_lack", 128'(wbm_lack_o), 128'(0));
      chk("rst_err", 128'(wbm_err_o), 128'(0));
      chk("rst_dat", 128'(wbm_dat_o), 128'(0));
      chk("rst_rrdy", 128'(res_rrdy_o), 128'(0));
      chk("rst_cval", 128'(cmd_val_o), 128'(0));
      chk("rst_cmd", 128'({cmd_adr_o, cmd_we_o, cmd_dat_o, cmd_sel_o, cmd_bl_o}), 128'(0));
      chk("rst_tid", 128'(cmd_tid_o), 128'(MID));
      @(posedge clk_i);
      #1;
      idle_inputs();
      rst_i = 1'b0;
      cycle();
      chk("post_rst_ack", 128'(s_ack), 128'(0));
      chk("post_rst_cval", 128'(s_cval), 128'(0));

      // Single write, fixed values.
      wr_burst(BL'(1), 32'h0000_0100, 32'hA5A5_0001, 1'b1, 100, 1'b0, -1);
      finish_cmds("single_wr");
      // Burst length 0 behaves as 1.
      wr_burst(BL'(0), $urandom, $urandom, 1'b1, 100, 1'b0, -1);
      finish_cmds("bl0_wr");
      // 4-beat write, command channel stalls 3 cycles after beat 2.
      wr_burst(BL'(4), $urandom, $urandom, 1'b1, 100, 1'b1, -1);
      finish_cmds("stall_wr");
      // Randomised write bursts.
      for (int i = 0; i < 6; i++) begin
         wr_burst(BL'($urandom_range(1, 6)), $urandom, $urandom, 1'b0, 60, 1'b0, -1);
         finish_cmds("rand_wr");
      end
      // Burst abandoned after 2 of 4 beats, then a fresh 2-beat burst.
      wr_burst(BL'(4), $urandom, $urandom, 1'b1, 100, 1'b0, 2);
      finish_cmds("abort_wr");
      wr_burst(BL'(2), $urandom, $urandom, 1'b1, 100, 1'b0, -1);
      finish_cmds("after_abort_wr");

      // 8-beat read with toggling bry.
      rd_burst(BL'(8), 0, -1, 0, 0);
      finish_cmds("rd8");
      // Response carrying the wrong TID.
      rd_burst(BL'(1), 0, 0, 0, 0);
      finish_cmds("rd_tid");
      // Master drops cyc after 2 of 4 responses.
      rd_burst(BL'(4), 0, -1, 2, 0);
      finish_cmds("rd_drop");
      // Read held off while a write command waits in the slot.
      wr_burst(BL'(1), $urandom, $urandom, 1'b1, 100, 1'b0, -1);
      rd_burst(BL'(3), 0, -1, 0, 2);
      finish_cmds("rd_blocked");
      // Randomised reads, including bl 0.
      rd_burst(BL'(0), 1, -1, 0, 0);
      finish_cmds("rd_bl0");
      for (int i = 0; i < 5; i++) begin
         rd_burst(BL'($urandom_range(1, 6)), 1, $urandom_range(0, 7), 0, 0);
         finish_cmds("rand_rd");
      end

      // Reset in the middle of a write burst with a command still pending.
      wbm_cyc_i  = 1'b1;
      wbm_stb_i  = 1'b1;
      wbm_we_i   = 1'b1;
      wbm_bry_i  = 1'b1;
      wbm_bl_i   = BL'(4);
      wbm_adr_i  = $urandom;
      wbm_dat_i  = $urandom;
      cmd_wrdy_i = 1'b1;
      cycle();
      cycle();
      cmd_wrdy_i = 1'b0;
      cycle();
      chk("mid_rst_pre_cval", 128'(cmd_val_o), 128'(1));
      #2;
      rst_i = 1'b1;
      #1;
      chk("mid_rst_cval", 128'(cmd_val_o), 128'(0));
      chk("mid_rst_ack", 128'(wbm_ack_o), 128'(0));
      chk("mid_rst_lack", 128'(wbm_lack_o), 128'(0));
      chk("mid_rst_cmd", 128'({cmd_adr_o, cmd_we_o, cmd_dat_o, cmd_sel_o, cmd_bl_o}), 128'(0));
      chk("mid_rst_tid", 128'(cmd_tid_o), 128'(MID));
      @(posedge clk_i);
      #1;
      idle_inputs();
      rst_i = 1'b0;
      got_q.delete();
      exp_q.delete();
      occ = 1'b0;
      cycle();
      chk("mid_rst_after_ack", 128'(s_ack), 128'(0));
      chk("mid_rst_after_cval", 128'(s_cval), 128'(0));
      wr_burst(BL'(2), $urandom, $urandom, 1'b1, 100, 1'b0, -1);
      finish_cmds("restart_wr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wbi_master_node.md
WBI_MASTER_NODE -- requirements
Module: wbi_master_node

Interface
REQ-001 SHALL have parameters: AW 32 address width; DW 32 data width; BW 4 byte enables; BL 10 burst-count width; MID 4'h0 master TID stamped on commands.
REQ-002 SHALL have ports, one per line:
- clk_i  in  1  single clock
- rst_i  in  1  reset, asynchronous, active-high
- wbm_cyc_i, wbm_stb_i, wbm_we_i  in  1 each  Wishbone master request
- wbm_adr_i  in  AW  address
- wbm_dat_i  in  DW  write data
- wbm_sel_i  in  BW  byte enables
- wbm_bl_i  in  BL  burst count
- wbm_bry_i  in  1  write beat available / read data accepted
- wbm_dat_o  out  DW  read data
- wbm_ack_o, wbm_lack_o, wbm_err_o  out  1 each  ack, last ack, error
- cmd_val_o  out  1  command valid
- cmd_wrdy_i  in  1  command accepted
- cmd_adr_o, cmd_we_o, cmd_dat_o, cmd_sel_o, cmd_bl_o  out  AW, 1, DW, BW, BL  command fields
- cmd_tid_o  out  4  always MID
- res_rval_i  in  1  response valid
- res_rrdy_o  out  1  response ready
- res_dat_i, res_lack_i, res_err_i, res_tid_i  in  DW, 1, 1, 4  response fields

Function
REQ-003 SHALL hold one registered command slot (valid bit plus fields) that drives cmd_*; the slot empties on cmd_val_o && cmd_wrdy_i.
REQ-004 SHALL accept a beat ("capture") when the slot is empty or is emptying in the same cycle.
REQ-005 SHALL use FSM states IDLE, WR_BURST, RD_WAIT; reset state IDLE.
REQ-006 IDLE: on cyc&stb&we&bry with capture possible, SHALL capture beat 1 and assert wbm_ack_o combinationally in that cycle. It then goes to WR_BURST, or stays in IDLE with wbm_lack_o=1 if the effective BL is 1.
REQ-007 Effective BL: wbm_bl_i==0 SHALL be treated as 1; the beat counter width is BL.
REQ-008 WR_BURST: each cyc&stb&bry with capture possible SHALL capture one beat and pulse wbm_ack_o. wbm_lack_o SHALL be asserted with the beat where counter == effective BL, and the FSM then returns to IDLE.
REQ-009 Write commands SHALL carry cmd_bl_o equal to the latched effective BL on every beat; no response is expected for writes.
REQ-010 IDLE: on cyc&stb&!we with capture possible, SHALL capture a single read command (dat 0) and go to RD_WAIT; no ack is given at capture.
REQ-011 RD_WAIT: res_rrdy_o = wbm_bry_i && cyc_i. wbm_ack_o = res_rval_i && res_rrdy_o. wbm_dat_o = res_dat_i. wbm_lack_o = ack && res_lack_i. On lack the FSM returns to IDLE.
REQ-012 wbm_err_o SHALL be ack && (res_err_i || res_tid_i != MID); a TID mismatch does not change the state transition.
REQ-013 Outside RD_WAIT, res_rrdy_o SHALL be 0; wbm_ack_o/lack/err SHALL be 0 except per REQ-006/008.
REQ-014 wbm_cyc_i dropping in WR_BURST SHALL return the FSM to IDLE; a captured beat remains valid until accepted.
REQ-015 wbm_cyc_i dropping in RD_WAIT SHALL force res_rrdy_o=1 with no ack, draining responses until res_lack_i, then IDLE.
REQ-016 A new read SHALL NOT be captured while the slot holds an unaccepted command.
REQ-017 The FSM SHALL remain in IDLE while cyc_i=0; cmd_val_o SHALL never deassert before acceptance.

Reset
REQ-018 rst_i SHALL asynchronously force: FSM IDLE, slot invalid, beat counter 0, cmd_val_o 0.
REQ-019 During reset, all outputs SHALL be 0 except cmd_tid_o=MID.
REQ-020 Reset mid-burst SHALL discard the slot and counters; no ack follows reset deassertion until a new request.

Structure
REQ-021 Package wbi_pkg SHALL hold the FSM state enum and the TID width constant (4).
REQ-022 The command slot SHALL be sub-module wbi_cmd_slot (1-entry valid/ready register, parameterised width).

Verification
REQ-023 Single write: adr 0x100, dat 0xA5A5_0001, bl 1, cmd_wrdy_i=1 -> ack+lack in the same cycle; cmd_val_o next cycle with bl 1, tid MID.
REQ-024 4-beat write with cmd_wrdy_i low for 3 cycles after beat 2 -> acks stall; 4 commands issued in order; lack on beat 4 only.
REQ-025 Read bl 8: responses 0..7 with wbm_bry_i toggled 1/0 -> 8 acks, data 0..7 in order, lack on 8th, then IDLE.
REQ-026 Read whose response has res_tid_i=MID+1 -> wbm_err_o=1 with that ack.
REQ-027 cyc dropped after 2 of 4 read responses -> no further acks; remaining 2 drained; IDLE after lack.
REQ-028 rst_i asserted mid write burst -> cmd_val_o 0 asynchronously; next request restarts at beat 1.
